// File: rtl/adder_pipe.sv
// adder_pipe: segmented-carry pipelined add/sub with
// valid/ready handshake and registered ALU status flags.
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             v_out,
  output logic             z_out,
  output logic             n_out
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             stall;
  logic [WIDTH-1:0] b_cond;
  logic             c0;

  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;

  logic [STAGES-1:0]            src_v, src_c;
  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_s;

  logic vf_d, vf_q;
  logic z_d, z_q;
  logic n_d, n_q;
  logic unused_tail;

  function automatic logic [SEG:0] seg_add(
    input logic [SEG-1:0] x,
    input logic [SEG-1:0] y,
    input logic           ci
  );
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  assign stall    = v_q[LAST] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    b_cond = in_2;
    c0     = 1'b0;
    unique case (op)
      2'b00: begin b_cond = in_2;  c0 = 1'b0; end
      2'b01: begin b_cond = ~in_2; c0 = 1'b1; end
      2'b10: begin b_cond = in_2;  c0 = cin;  end
      2'b11: begin b_cond = ~in_2; c0 = cin;  end
      default: ;
    endcase
  end

  // Stage s consumes the bundle registered by stage s-1.
  always_comb begin
    src_v    = '0;
    src_c    = '0;
    src_a    = '0;
    src_b    = '0;
    src_s    = '0;
    src_v[0] = in_valid & in_ready;
    src_c[0] = c0;
    src_a[0] = in_1;
    src_b[0] = b_cond;
    for (int s = 1; s < STAGES; s++) begin
      src_v[s] = v_q[s-1];
      src_c[s] = c_q[s-1];
      src_a[s] = a_q[s-1];
      src_b[s] = b_q[s-1];
      src_s[s] = s_q[s-1];
    end
  end

  always_comb begin
    logic [SEG:0] t;
    t   = '0;
    v_d = src_v;
    a_d = src_a;
    b_d = src_b;
    s_d = src_s;
    c_d = '0;
    for (int s = 0; s < STAGES; s++) begin
      t = seg_add(src_a[s][s*SEG +: SEG],
                  src_b[s][s*SEG +: SEG],
                  src_c[s]);
      s_d[s][s*SEG +: SEG] = t[SEG-1:0];
      c_d[s] = t[SEG];
    end
    // carry into the MSB recovered as a ^ b ^ sum at that bit
    vf_d = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1]
         ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
    z_d  = (s_d[LAST] == '0);
    n_d  = s_d[LAST][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      c_q  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      vf_q <= 1'b0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
    end else if (!stall) begin
      v_q  <= v_d;
      c_q  <= c_d;
      a_q  <= a_d;
      b_q  <= b_d;
      s_q  <= s_d;
      vf_q <= vf_d;
      z_q  <= z_d;
      n_q  <= n_d;
    end
  end

  assign unused_tail = ^{a_q[LAST], b_q[LAST]};

  assign out_valid = v_q[LAST];
  assign out       = s_q[LAST];
  assign c_out     = c_q[LAST];
  assign v_out     = vf_q;
  assign z_out     = z_q;
  assign n_out     = n_q;

endmodule
